// File: rtl/keypad_entry_display_pkg.sv
// Shared types and constants for the keypad entry / seven-segment display block.
// Segment patterns are {g,f,e,d,c,b,a} with 1 = lit.
package keypad_entry_display_pkg;

  typedef enum logic {
    KEY_IDLE = 1'b0,
    KEY_HELD = 1'b1
  } key_state_t;

  localparam logic [3:0] DEFAULT_ENTER_CODE = 4'hE;
  localparam logic [3:0] DEFAULT_CLEAR_CODE = 4'hC;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ZERO  = 7'h3F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] pattern;
    case (hex)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/keypad_entry_display_seg7_decode.sv
// Combinational hex digit to seven-segment pattern lookup.
module seg7_decode
  import keypad_entry_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb seg = hex_to_seg(hex);

endmodule

// File: rtl/keypad_entry_display.sv
// Keypad digit entry buffer with committed-value handshake and a
// multiplexed seven-segment display of the digits being entered.
module keypad_entry_display
  import keypad_entry_display_pkg::*;
#(
  parameter int         NUM_DIGITS = 4,
  parameter int         SCAN_W     = 16,
  parameter logic [3:0] ENTER_CODE = DEFAULT_ENTER_CODE,
  parameter logic [3:0] CLEAR_CODE = DEFAULT_CLEAR_CODE,
  parameter bit         BLANK_LEAD = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              key_down,
  input  logic [3:0]                        key_code,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [4*NUM_DIGITS-1:0]           out_value,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   out_count,
  output logic                              overflow,
  output logic [NUM_DIGITS-1:0]             digit_en,
  output logic [6:0]                        seg
);

  localparam int BUF_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(NUM_DIGITS);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
  localparam logic [SCAN_W-1:0]     SCAN_ONE   = SCAN_W'(1);
  localparam logic [NUM_DIGITS-1:0] EN_FIRST   = NUM_DIGITS'(1);

  key_state_t        key_state;
  logic              rearm;
  logic [BUF_W-1:0]  buffer;
  logic [CNT_W-1:0]  count;
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  index;
  logic [3:0]        cur_digit;
  logic [6:0]        cur_seg;
  logic              blank;

  // A key held through reset must be released before it can act again, so
  // reset records whether the key was down and blocks presses until release.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_state <= KEY_IDLE;
      rearm     <= key_down;
      buffer    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_count <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (!key_down) rearm <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (key_state)
        KEY_IDLE: begin
          if (key_down && !rearm) begin
            key_state <= KEY_HELD;
            if (key_code == CLEAR_CODE) begin
              buffer <= '0;
              count  <= '0;
            end else if (!out_valid) begin
              if (key_code == ENTER_CODE) begin
                if (count != '0) begin
                  out_valid <= 1'b1;
                  out_value <= buffer;
                  out_count <= count;
                  buffer    <= '0;
                  count     <= '0;
                end
              end else if (key_code <= 4'd9) begin
                if (count < FULL_COUNT) begin
                  buffer <= {buffer[BUF_W-5:0], key_code};
                  count  <= count + CNT_ONE;
                end else begin
                  overflow <= 1'b1;
                end
              end
            end
          end
        end
        KEY_HELD: begin
          if (!key_down) key_state <= KEY_IDLE;
        end
        default: key_state <= KEY_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      index    <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_ONE;
      if (scan_cnt == '1) index <= (index == LAST_IDX) ? '0 : index + IDX_ONE;
    end
  end

  assign cur_digit = buffer[{index, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .hex (cur_digit),
    .seg (cur_seg)
  );

  // Digit 0 stays visible as '0' on an empty entry so the display is never fully dark.
  assign blank = BLANK_LEAD && (CNT_W'(index) >= count) && ((index != '0) || (count != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_en <= EN_FIRST;
      seg      <= SEG_ZERO;
    end else begin
      digit_en <= EN_FIRST << index;
      seg      <= blank ? SEG_BLANK : cur_seg;
    end
  end

endmodule

// File: tb/tb_keypad_entry_display.sv
// Randomized bench for keypad_entry_display compared every cycle against
// a queue-based reference model of digit entry, commit and display scan.
module tb_keypad_entry_display;

  localparam int         NUM_DIGITS = 4;
  localparam int         SCAN_W     = 4;
  localparam logic [3:0] ENTER      = 4'hE;
  localparam logic [3:0] CLEAR      = 4'hC;
  localparam int         CNT_W      = $clog2(NUM_DIGITS + 1);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    key_down = 1'b0;
  logic [3:0]              key_code = 4'h0;
  logic                    out_ready = 1'b0;
  logic                    out_valid;
  logic [4*NUM_DIGITS-1:0] out_value;
  logic [CNT_W-1:0]        out_count;
  logic                    overflow;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [6:0]              seg;

  int checks = 0;
  int errors = 0;

  int                      m_digits[$];
  bit                      m_held, m_rearm, m_valid, m_overflow;
  logic [4*NUM_DIGITS-1:0] m_value;
  int                      m_count_out;
  int                      m_cycles;
  logic [NUM_DIGITS-1:0]   e_digit_en;
  logic [6:0]              e_seg;
  int                      m_idx, m_n;
  bit                      m_press, m_valid_before;

  keypad_entry_display #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_W     (SCAN_W),
    .ENTER_CODE (ENTER),
    .CLEAR_CODE (CLEAR),
    .BLANK_LEAD (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_down  (key_down),
    .key_code  (key_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_count (out_count),
    .overflow  (overflow),
    .digit_en  (digit_en),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] refSeg(input int d);
    case (d)
      0: return 7'b0111111;  1: return 7'b0000110;
      2: return 7'b1011011;  3: return 7'b1001111;
      4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;
      8: return 7'b1111111;  9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference model: display reflects the state before each edge, then the edge's key action is applied.
  always @(posedge clk) begin
    if (rst) begin
      m_digits.delete();
      m_held      = 1'b0;
      m_rearm     = key_down;
      m_valid     = 1'b0;
      m_value     = '0;
      m_count_out = 0;
      m_overflow  = 1'b0;
      m_cycles    = 0;
      e_digit_en  = 1;
      e_seg       = refSeg(0);
    end else begin
      m_idx = (m_cycles / (1 << SCAN_W)) % NUM_DIGITS;
      m_n   = m_digits.size();
      e_digit_en = '0;
      e_digit_en[m_idx] = 1'b1;
      if (m_idx < m_n) e_seg = refSeg(m_digits[m_n - 1 - m_idx]);
      else if (m_idx == 0) e_seg = refSeg(0);
      else e_seg = 7'h00;
      m_cycles++;

      m_press = key_down && !m_held && !m_rearm;
      m_held  = key_down;
      if (!key_down) m_rearm = 1'b0;
      m_valid_before = m_valid;
      m_overflow = 1'b0;
      if (m_valid_before && out_ready) m_valid = 1'b0;
      if (m_press) begin
        if (key_code == CLEAR) begin
          m_digits.delete();
        end else if (!m_valid_before) begin
          if (key_code == ENTER) begin
            if (m_n > 0) begin
              m_value = '0;
              foreach (m_digits[i]) m_value = m_value * 16 + m_digits[i];
              m_count_out = m_n;
              m_valid = 1'b1;
              m_digits.delete();
            end
          end else if (key_code <= 4'd9) begin
            if (m_n < NUM_DIGITS) m_digits.push_back(int'(key_code));
            else m_overflow = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("out_value", 32'(out_value), 32'(m_value));
    checkOutput("out_count", 32'(out_count), 32'(m_count_out));
    checkOutput("overflow",  32'(overflow),  32'(m_overflow));
    checkOutput("digit_en",  32'(digit_en),  32'(e_digit_en));
    checkOutput("seg",       32'(seg),       32'(e_seg));
  endtask

  task automatic applyStimulus(input bit r, input bit kd, input logic [3:0] code, input bit rdy);
    @(negedge clk);
    checkAll();
    rst       = r;
    key_down  = kd;
    key_code  = code;
    out_ready = rdy;
  endtask

  task automatic pressKey(input logic [3:0] code, input int hold, input int gap, input bit rdy);
    repeat (hold) applyStimulus(1'b0, 1'b1, code, rdy);
    repeat (gap)  applyStimulus(1'b0, 1'b0, 4'h0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) applyStimulus(1'b0, 1'b0, 4'h0, rdy);
  endtask

  bit         r_down;
  logic [3:0] r_code;

  initial begin
    repeat (3) applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    idle(2, 1'b0);

    // Entry of 1,2,3 then a full scan pass to see digits 3,2,1 and a blank slot
    pressKey(4'd1, 3, 2, 1'b0);
    pressKey(4'd2, 2, 3, 1'b0);
    pressKey(4'd3, 4, 1, 1'b0);
    idle(80, 1'b0);

    // Overflow on the fifth digit
    pressKey(CLEAR, 2, 2, 1'b0);
    for (int d = 1; d <= 5; d++) pressKey(4'(d), 2, 2, 1'b0);
    idle(70, 1'b0);

    // Commit 42 and hold it pending, then release with out_ready
    pressKey(CLEAR, 2, 2, 1'b0);
    pressKey(4'd4, 2, 2, 1'b0);
    pressKey(4'd2, 2, 2, 1'b0);
    pressKey(ENTER, 2, 2, 1'b0);
    idle(10, 1'b0);
    idle(3, 1'b1);

    // Empty enter and a very long hold
    pressKey(ENTER, 3, 3, 1'b0);
    pressKey(4'd5, 1000, 3, 1'b0);

    // Clear mid-entry, then pending commit blocks digits but not clear
    pressKey(CLEAR, 2, 2, 1'b0);
    pressKey(4'd7, 2, 2, 1'b0);
    pressKey(CLEAR, 2, 2, 1'b0);
    pressKey(4'd8, 2, 2, 1'b0);
    pressKey(ENTER, 2, 2, 1'b0);
    pressKey(4'd6, 2, 2, 1'b0);
    pressKey(ENTER, 2, 2, 1'b0);
    pressKey(4'd9, 2, 2, 1'b0);
    pressKey(CLEAR, 2, 2, 1'b0);
    pressKey(4'd3, 2, 2, 1'b1);

    // Reset while a key is held, with a handshake and press in the same cycle before it
    pressKey(ENTER, 2, 0, 1'b0);
    pressKey(4'd1, 2, 2, 1'b1);
    pressKey(4'd3, 2, 0, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b1, 4'd3, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b1, 4'd3, 1'b0);
    idle(2, 1'b0);
    pressKey(4'd6, 2, 2, 1'b0);

    // Randomized key activity
    r_down = 1'b0;
    r_code = 4'h0;
    for (int c = 0; c < 4000; c++) begin
      if (r_down) begin
        if ($urandom_range(0, 3) == 0) r_down = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        r_down = 1'b1;
        if ($urandom_range(0, 3) == 0) r_code = 4'($urandom_range(10, 15));
        else r_code = 4'($urandom_range(0, 9));
      end
      applyStimulus(($urandom_range(0, 599) == 0), r_down, r_code, ($urandom_range(0, 3) == 0));
    end
    idle(3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry_display.md
KEYPAD_ENTRY_DISPLAY -- requirements
Module: keypad_entry_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of buffered/displayed digits (2..8).
REQ-002 SHALL have parameter SCAN_W, default 16, width of the display scan counter.
REQ-003 SHALL have parameter ENTER_CODE, default 4'hE, key code that commits the entry.
REQ-004 SHALL have parameter CLEAR_CODE, default 4'hC, key code that clears the entry.
REQ-005 SHALL have parameter BLANK_LEAD, default 1, 1 = unentered digits dark, 0 = shown as '0'.
REQ-006 SHALL have port clk, input, 1, system clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port key_down, input, 1, debounced, clk-synchronous key-held level.
REQ-009 SHALL have port key_code, input, 4, decoded key value, valid while key_down=1.
REQ-010 SHALL have port out_valid, output, 1, committed value available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the committed value.
REQ-012 SHALL have port out_value, output, 4*NUM_DIGITS, committed digits, newest digit in [3:0].
REQ-013 SHALL have port out_count, output, $clog2(NUM_DIGITS+1), number of digits committed.
REQ-014 SHALL have port overflow, output, 1, one-cycle pulse when a digit is rejected because the buffer is full.
REQ-015 SHALL have port digit_en, output, NUM_DIGITS, one-hot active-high digit select.
REQ-016 SHALL have port seg, output, 7, {g,f,e,d,c,b,a}, 1 = segment lit.

Function
REQ-017 SHALL use a two-state key FSM: IDLE -> HELD when key_down=1, HELD -> IDLE when key_down=0; a key action occurs only on the IDLE->HELD transition.
REQ-018 SHALL apply every key action at the same clock edge as the IDLE->HELD transition, so that buffer and count show the result the cycle after key_down is first sampled high.
REQ-019 SHALL, for code 0..9 with count<NUM_DIGITS, shift the buffer left by 4 bits, load the code into [3:0] and increment count.
REQ-020 SHALL, for code 0..9 with count==NUM_DIGITS, leave the buffer unchanged and pulse overflow for exactly one cycle.
REQ-021 SHALL, for CLEAR_CODE, zero the buffer and count; a pending out_valid is unaffected.
REQ-022 SHALL, for ENTER_CODE with count>0 and out_valid=0, copy the buffer to out_value and the count to out_count, set out_valid, and then zero the buffer and count.
REQ-023 SHALL ignore ENTER_CODE when count==0, and ignore any other non-digit code.
REQ-024 SHALL ignore all key actions except CLEAR_CODE while out_valid=1, evaluated on the registered out_valid.
REQ-025 SHALL hold out_valid, out_value and out_count stable until a cycle with out_valid=1 and out_ready=1, then clear out_valid on the next edge.
REQ-026 SHALL, when a handshake and a key press occur in the same cycle, complete the handshake and apply REQ-024 to the press.
REQ-027 SHALL advance the digit index, mod NUM_DIGITS, with wrap NUM_DIGITS-1 -> 0, in the cycle after the free-running SCAN_W-bit counter reaches all-ones.
REQ-028 SHALL drive digit_en as one-hot of the index, with seg showing buffer digit [index] through the seven-segment decoder.
REQ-029 SHALL force seg=0 when BLANK_LEAD=1 and index>=count, except at index 0 when count==0, which shows '0'.
REQ-030 SHALL register digit_en and seg so that both change on the same edge.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set: FSM=IDLE, buffer=0, count=0, out_valid=0, out_value=0, out_count=0, overflow=0, scan counter=0, index=0, digit_en=1, seg=decode('0').
REQ-032 SHALL let reset asserted mid-press drop any pending action, and SHALL require key_down to return to 0 before the next action after reset.

Structure
REQ-033 SHALL keep the seven-segment patterns for 0-F and the default ENTER/CLEAR codes in the shared package.
REQ-034 SHALL implement the hex-to-segment lookup as one combinational sub-module, seg7_decode; everything else stays in this module.

Verification
REQ-035 SHALL cover: reset, then presses 1,2,3 -> buffer 0x0123, count=3; display scan shows digits 3,2,1, index-3 digit blank.
REQ-036 SHALL cover: presses 1,2,3,4,5 with NUM_DIGITS=4 -> buffer 0x1234, overflow pulses once on '5'.
REQ-037 SHALL cover: 4,2,ENTER with out_ready=0 for 10 cycles -> out_valid=1, out_value=0x0042, out_count=2, stable; buffer=0; raising out_ready clears out_valid the next cycle.
REQ-038 SHALL cover: ENTER with count=0 -> no out_valid; key_down held 1000 cycles -> exactly one action.
REQ-039 SHALL cover: 7, CLEAR, 8 -> buffer 0x0008; with out_valid pending, digit 9 ignored and CLEAR accepted.
REQ-040 SHALL cover: SCAN_W=4 -> digit_en steps 0001,0010,0100,1000,0001 every 16 cycles; rst mid-HELD -> all reset values, no action until release.
